// File: rtl/div16u8_seq.sv
// Iterative restoring 16/8 unsigned divider with valid/ready handshakes.
// APPROX_LSB low quotient bits are skipped (forced to zero) to shorten latency.
module div16u8_seq #(
  parameter int APPROX_LSB = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        div0,
  output logic        ovf
);

  localparam int ITER = 8 - APPROX_LSB;
  localparam logic [3:0] LAST = 4'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  p_q, p_d;
  logic [7:0]  s_q, s_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;

  logic [8:0]  t;
  logic [8:0]  p_sub;
  logic        qbit;

  // P stays below B, so the trial value fits in 9 bits and T - B fits in 8.
  assign t     = {p_q[7:0], s_q[7]};
  assign qbit  = (t >= {1'b0, b_q});
  assign p_sub = t - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    s_d     = s_q;
    quo_d   = quo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (B == 8'h00) begin
            state_d = DONE;
            div0_d  = 1'b1;
            ovf_d   = 1'b0;
            q_d     = 8'hFF;
            r_d     = 8'hFF;
          end else if (A[15:8] >= B) begin
            state_d = DONE;
            div0_d  = 1'b0;
            ovf_d   = 1'b1;
            q_d     = 8'hFF;
            r_d     = 8'hFF;
          end else begin
            state_d = CALC;
            p_d     = {1'b0, A[15:8]};
            s_d     = A[7:0];
            quo_d   = 8'h00;
            b_d     = B;
            cnt_d   = 4'd0;
          end
        end
      end
      CALC: begin
        p_d   = qbit ? p_sub : t;
        s_d   = {s_q[6:0], 1'b0};
        quo_d = {quo_q[6:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          q_d     = quo_d << APPROX_LSB;
          r_d     = (APPROX_LSB == 0) ? p_d[7:0] : 8'h00;
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= 9'd0;
      s_q     <= 8'd0;
      quo_q   <= 8'd0;
      b_q     <= 8'd0;
      cnt_q   <= 4'd0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div16u8_seq.sv
// Directed bench for div16u8_seq: exact (APPROX_LSB=0) and approximate (APPROX_LSB=3) instances.
module tb_div16u8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_ready;
  logic        in_valid0, in_valid3;
  logic        in_ready0, in_ready3;
  logic        out_valid0, out_valid3;
  logic [7:0]  q0, r0, q3, r3;
  logic        div0_0, ovf_0, div0_3, ovf_3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  div16u8_seq #(.APPROX_LSB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .A(A), .B(B), .out_valid(out_valid0), .out_ready(out_ready),
    .Q(q0), .R(r0), .div0(div0_0), .ovf(ovf_0)
  );

  div16u8_seq #(.APPROX_LSB(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .A(A), .B(B), .out_valid(out_valid3), .out_ready(out_ready),
    .Q(q3), .R(r3), .div0(div0_3), .ovf(ovf_3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and returns the edge count to out_valid (accept edge = 1), -1 on timeout.
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [7:0] b, output int n);
    A = a;
    B = b;
    if (sel) in_valid3 = 1'b1; else in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    in_valid3 = 1'b0;
    n = 1;
    while (!(sel ? out_valid3 : out_valid0) && n < 30) begin
      step();
      n++;
    end
    if (!(sel ? out_valid3 : out_valid0)) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid0 = 1'b0;
    in_valid3 = 1'b0;
    out_ready = 1'b0;
    A = 16'h0;
    B = 8'h0;
    step();
    step();
    rst_n = 1'b1;
    total_cnt++;
    if ({in_ready0, out_valid0, q0, r0, div0_0, ovf_0} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset0: rdy=%b vld=%b Q=%h R=%h d0=%b ov=%b want rdy=1 vld=0 Q=00 R=00 flags 0",
               in_ready0, out_valid0, q0, r0, div0_0, ovf_0);
    else pass_cnt++;
    total_cnt++;
    if ({in_ready3, out_valid3, q3, r3, div0_3, ovf_3} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset3: rdy=%b vld=%b Q=%h R=%h d0=%b ov=%b want rdy=1 vld=0 Q=00 R=00 flags 0",
               in_ready3, out_valid3, q3, r3, div0_3, ovf_3);
    else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    run_op(1'b0, 16'h1234, 8'h56, n);
    $display("op 1234/56: n=%0d Q=%h R=%h d0=%b ov=%b", n, q0, r0, div0_0, ovf_0);
    total_cnt++;
    if (n !== 9) $display("FAIL basic_latency: got %0d want 9", n); else pass_cnt++;
    total_cnt++;
    if ({q0, r0, div0_0, ovf_0} !== {8'h36, 8'h10, 1'b0, 1'b0})
      $display("FAIL basic_result: Q=%h R=%h d0=%b ov=%b want Q=36 R=10 flags 0", q0, r0, div0_0, ovf_0);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({in_ready0, out_valid0} !== 2'b10)
      $display("FAIL basic_return_idle: rdy=%b vld=%b want rdy=1 vld=0", in_ready0, out_valid0);
    else pass_cnt++;
  endtask

  task automatic test_exact_and_ovf();
    int n;
    out_ready = 1'b1;
    run_op(1'b0, 16'hFE01, 8'hFF, n);
    $display("op FE01/FF: n=%0d Q=%h R=%h d0=%b ov=%b", n, q0, r0, div0_0, ovf_0);
    total_cnt++;
    if ({n == 9, q0, r0, div0_0, ovf_0} !== {1'b1, 8'hFF, 8'h00, 1'b0, 1'b0})
      $display("FAIL max_quot: n=%0d Q=%h R=%h d0=%b ov=%b want n=9 Q=FF R=00 flags 0", n, q0, r0, div0_0, ovf_0);
    else pass_cnt++;
    step();
    run_op(1'b0, 16'h5600, 8'h56, n);
    $display("op 5600/56: n=%0d Q=%h R=%h d0=%b ov=%b", n, q0, r0, div0_0, ovf_0);
    total_cnt++;
    if (n !== 1) $display("FAIL ovf_latency: got %0d want 1", n); else pass_cnt++;
    total_cnt++;
    if ({q0, r0, div0_0, ovf_0} !== {8'hFF, 8'hFF, 1'b0, 1'b1})
      $display("FAIL ovf_result: Q=%h R=%h d0=%b ov=%b want Q=FF R=FF d0=0 ov=1", q0, r0, div0_0, ovf_0);
    else pass_cnt++;
    step();
  endtask

  task automatic test_div0();
    int n;
    out_ready = 1'b1;
    run_op(1'b0, 16'h1234, 8'h00, n);
    $display("op 1234/00: n=%0d Q=%h R=%h d0=%b ov=%b", n, q0, r0, div0_0, ovf_0);
    total_cnt++;
    if (n !== 1) $display("FAIL div0_latency: got %0d want 1", n); else pass_cnt++;
    total_cnt++;
    if ({q0, r0, div0_0, ovf_0} !== {8'hFF, 8'hFF, 1'b1, 1'b0})
      $display("FAIL div0_result: Q=%h R=%h d0=%b ov=%b want Q=FF R=FF d0=1 ov=0", q0, r0, div0_0, ovf_0);
    else pass_cnt++;
    step();
  endtask

  task automatic test_approx();
    int n;
    out_ready = 1'b1;
    run_op(1'b1, 16'h1234, 8'h56, n);
    $display("approx3 1234/56: n=%0d Q=%h R=%h d0=%b ov=%b", n, q3, r3, div0_3, ovf_3);
    total_cnt++;
    if (n !== 6) $display("FAIL approx_latency: got %0d want 6", n); else pass_cnt++;
    total_cnt++;
    if ({q3, r3, div0_3, ovf_3} !== {8'h30, 8'h00, 1'b0, 1'b0})
      $display("FAIL approx_result: Q=%h R=%h d0=%b ov=%b want Q=30 R=00 flags 0", q3, r3, div0_3, ovf_3);
    else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    out_ready = 1'b0;
    run_op(1'b0, 16'h0FA3, 8'h21, n);
    // 0x0FA3 = 4003 = 121*33 + 10
    $display("op 0FA3/21 held: n=%0d Q=%h R=%h", n, q0, r0);
    total_cnt++;
    if ({n == 9, q0, r0} !== {1'b1, 8'h79, 8'h0A})
      $display("FAIL bp_result: n=%0d Q=%h R=%h want n=9 Q=79 R=0A", n, q0, r0);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid0 = ~in_valid0;
      A = A + 16'h0111;
      step();
      if ({out_valid0, in_ready0, q0, r0} !== {1'b1, 1'b0, 8'h79, 8'h0A}) bad++;
    end
    in_valid0 = 1'b0;
    total_cnt++;
    if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles want 0", bad); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({out_valid0, in_ready0} !== 2'b01)
      $display("FAIL bp_release: vld=%b rdy=%b want vld=0 rdy=1", out_valid0, in_ready0);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid0, in_ready0} !== 2'b01)
      $display("FAIL bp_idle_stays: vld=%b rdy=%b want vld=0 rdy=1", out_valid0, in_ready0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midcalc();
    int n;
    out_ready = 1'b1;
    A = 16'h1234;
    B = 8'h56;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    $display("reset midcalc: vld=%b rdy=%b Q=%h R=%h", out_valid0, in_ready0, q0, r0);
    total_cnt++;
    if ({out_valid0, in_ready0, q0, r0, div0_0, ovf_0} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0})
      $display("FAIL midcalc_reset: vld=%b rdy=%b Q=%h R=%h d0=%b ov=%b want vld=0 rdy=1 Q=00 R=00 flags 0",
               out_valid0, in_ready0, q0, r0, div0_0, ovf_0);
    else pass_cnt++;
    run_op(1'b0, 16'h0064, 8'h0A, n);
    $display("op 0064/0A: n=%0d Q=%h R=%h", n, q0, r0);
    total_cnt++;
    if ({n == 9, q0, r0, div0_0, ovf_0} !== {1'b1, 8'h0A, 8'h00, 1'b0, 1'b0})
      $display("FAIL post_reset_op: n=%0d Q=%h R=%h want n=9 Q=0A R=00", n, q0, r0);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact_and_ovf();
    test_div0();
    test_approx();
    test_backpressure();
    test_reset_midcalc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
